// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end placed directly in front of the decoder. It owns
// the program counter and issues word reads to an instruction ROM with one
// cycle of read latency. Returned words are tagged with their PC and held in a
// small prefetch FIFO. The FIFO head goes to decode through a valid/ready
// handshake. A redirect from execute flushes the FIFO, drops any response that
// is in flight, and restarts fetch at the new address.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   rom_read     fetch request issued this cycle
//   rom_address  byte address of the request (always word-aligned)
//   rom_data     instruction word, valid the cycle after the request
//   redirect     flush and restart fetch at redirect_pc
//   redirect_pc  new fetch address (low two bits are expected to be zero)
//   out_valid    FIFO head is valid
//   out_ready    decode accepts the head
//   out_instr    instruction at the head
//   out_pc       PC of the head instruction
//   out_next_pc  out_pc + 4, modulo 2^ADDR_WIDTH
//   count        current FIFO occupancy
//   error        sticky flag: misaligned redirect or FIFO overflow
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        rom_read,
    output logic [ADDR_WIDTH-1:0]       rom_address,
    input  logic [31:0]                 rom_data,
    input  logic                        redirect,
    input  logic [ADDR_WIDTH-1:0]       redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_instr,
    output logic [ADDR_WIDTH-1:0]       out_pc,
    output logic [ADDR_WIDTH-1:0]       out_next_pc,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Fetch control state
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  vld_p0;     // a ROM request is in flight
    logic [ADDR_WIDTH-1:0] pc_p0;      // address of the in-flight request

    // Prefetch FIFO
    logic [31:0]           instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  error_q;

    logic                  pop;
    logic                  push;
    logic                  full;
    logic                  overflow;
    logic                  wr_en;
    logic                  issue;
    logic                  misaligned;
    logic [CNT_W:0]        pending;

    function automatic logic [ADDR_WIDTH-1:0] align_word(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:2], 2'b00};
    endfunction

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign push      = vld_p0 & ~redirect;
    // The credit rule below prevents this; if it ever happens the word is lost
    // and the sticky error flag records it.
    assign overflow  = push & full & ~pop;
    assign wr_en     = push & ~overflow;

    // Credit check: entries already buffered plus the one still coming back
    // from ROM, less the one leaving this cycle, must leave room for another.
    // Depends on out_ready combinationally so a full FIFO can refill without
    // a bubble.
    assign pending   = {1'b0, count_q} + (CNT_W+1)'(vld_p0) - (CNT_W+1)'(pop);
    assign issue     = ~reset & ~redirect & (pending < (CNT_W+1)'(DEPTH));

    assign misaligned = (redirect_pc[1:0] != 2'b00);

    assign rom_read    = issue;
    assign rom_address = fetch_pc;

    // Head is read from FIFO storage registers only; rom_data never reaches
    // the outputs combinationally.
    assign out_instr   = instr_mem[rd_ptr];
    assign out_pc      = pc_mem[rd_ptr];
    assign out_next_pc = out_pc + ADDR_WIDTH'(4);
    assign count       = count_q;
    assign error       = error_q;

    // ---- stage p0: request issue / flush control ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            vld_p0   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= align_word(redirect_pc);
            vld_p0   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count_q  <= '0;
            if (misaligned) begin
                error_q <= 1'b1;
            end
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
            end
            vld_p0 <= issue;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(wr_en) - CNT_W'(pop);
            if (overflow) begin
                error_q <= 1'b1;
            end
        end
    end

    // ---- stage p0 data: remember the address of the outstanding request ----
    always_ff @(posedge clk) begin
        if (issue) begin
            pc_p0 <= fetch_pc;
        end
    end

    // ---- stage p1: ROM response written into the FIFO ----
    always_ff @(posedge clk) begin
        if (wr_en) begin
            instr_mem[wr_ptr] <= rom_data;
            pc_mem[wr_ptr]    <= pc_p0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_ready;

    // Main DUT (RESET_PC = 0)
    logic        rom_read;
    logic [15:0] rom_address;
    logic [31:0] rom_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_next_pc;
    logic [2:0]  count;
    logic        error;

    // Wrap-around DUT (RESET_PC = 0xFFF8), always ready, never redirected
    logic        rom_read_w;
    logic [15:0] rom_address_w;
    logic [31:0] rom_data_w;
    logic        out_valid_w;
    logic [31:0] out_instr_w;
    logic [15:0] out_pc_w;
    logic [15:0] out_next_pc_w;
    logic [2:0]  count_w;
    logic        error_w;
    logic        ready_w;
    logic        redirect_w;
    logic [15:0] redirect_pc_w;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.ADDR_WIDTH(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .rom_read    (rom_read),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_next_pc (out_next_pc),
        .count       (count),
        .error       (error)
    );

    fetch_unit #(.ADDR_WIDTH(16), .DEPTH(4), .RESET_PC(16'hFFF8)) dut_w (
        .clk         (clk),
        .reset       (reset),
        .rom_read    (rom_read_w),
        .rom_address (rom_address_w),
        .rom_data    (rom_data_w),
        .redirect    (redirect_w),
        .redirect_pc (redirect_pc_w),
        .out_valid   (out_valid_w),
        .out_ready   (ready_w),
        .out_instr   (out_instr_w),
        .out_pc      (out_pc_w),
        .out_next_pc (out_next_pc_w),
        .count       (count_w),
        .error       (error_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return 32'(a >> 2);
    endfunction

    // ROM with one cycle of read latency; returns junk when not read
    always @(posedge clk) begin
        rom_data   <= rom_read   ? rom_word(rom_address)   : 32'hDEAD_BEEF;
        rom_data_w <= rom_read_w ? rom_word(rom_address_w) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_pc;
    logic        exp_err;
    logic        rdy;
    logic        redir;
    logic [15:0] target;
    int          pops;

    initial begin
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = 16'h0;
        out_ready     = 1'b0;
        ready_w       = 1'b1;
        redirect_w    = 1'b0;
        redirect_pc_w = 16'h0;

        // ---- reset state ----
        tick();
        tick();
        chk("rst_count",    32'(count),       32'd0);
        chk("rst_valid",    32'(out_valid),   32'd0);
        chk("rst_rom_read", 32'(rom_read),    32'd0);
        chk("rst_error",    32'(error),       32'd0);
        chk("rst_addr",     32'(rom_address), 32'h0);
        chk("rst_addr_w",   32'(rom_address_w), 32'hFFF8);

        // ---- release, out_ready=1: streaming, latency, wrap DUT ----
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rel_rom_read", 32'(rom_read),    32'd1);
        chk("rel_addr",     32'(rom_address), 32'h0);
        tick();
        chk("lat1_valid",   32'(out_valid),   32'd0);
        chk("lat1_addr",    32'(rom_address), 32'h4);
        tick();
        chk("lat2_valid",   32'(out_valid),   32'd1);
        chk("lat2_pc",      32'(out_pc),      32'h0);
        chk("lat2_instr",   out_instr,        32'h0);
        chk("lat2_next",    32'(out_next_pc), 32'h4);
        chk("wrap_pc0",     32'(out_pc_w),    32'hFFF8);
        chk("wrap_instr0",  out_instr_w,      32'h3FFE);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_pc",    32'(out_pc),    32'(4 * i));
            chk("stream_instr", out_instr,      32'(i));
            if (i == 1) begin
                chk("wrap_pc1",   32'(out_pc_w),      32'hFFFC);
                chk("wrap_next1", 32'(out_next_pc_w), 32'h0000);
            end
            if (i == 2) begin
                chk("wrap_pc2",   32'(out_pc_w),  32'h0000);
                chk("wrap_instr2", out_instr_w,   32'h0);
            end
        end
        chk("wrap_error", 32'(error_w), 32'd0);

        // ---- stall with out_ready=0: FIFO saturates, then drains in order ----
        reset     = 1'b1;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("stall_count",    32'(count),     32'd4);
        chk("stall_rom_read", 32'(rom_read),  32'd0);
        chk("stall_valid",    32'(out_valid), 32'd1);
        chk("stall_error",    32'(error),     32'd0);
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("drain_valid", 32'(out_valid), 32'd1);
            chk("drain_pc",    32'(out_pc),    32'(4 * i));
            chk("drain_instr", out_instr,      32'(i));
            tick();
        end
        chk("drain_error", 32'(error), 32'd0);

        // ---- asynchronous reset mid-cycle with the FIFO full ----
        out_ready = 1'b0;
        repeat (6) tick();
        chk("full_count", 32'(count), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid",    32'(out_valid),   32'd0);
        chk("async_rom_read", 32'(rom_read),    32'd0);
        chk("async_count",    32'(count),       32'd0);
        chk("async_addr",     32'(rom_address), 32'h0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("restart_read", 32'(rom_read),    32'd1);
        chk("restart_addr", 32'(rom_address), 32'h0);
        tick();
        tick();
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_pc",    32'(out_pc),    32'h0);

        // ---- redirect with 3 buffered and one in flight ----
        reset     = 1'b1;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("pre_redir_count", 32'(count),    32'd3);
        chk("pre_redir_read",  32'(rom_read), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        chk("redir_no_issue", 32'(rom_read), 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("post_redir_count", 32'(count),       32'd0);
        chk("post_redir_valid", 32'(out_valid),   32'd0);
        chk("post_redir_addr",  32'(rom_address), 32'h40);
        chk("post_redir_read",  32'(rom_read),    32'd1);
        tick();
        chk("redir_lat_valid", 32'(out_valid), 32'd0);
        tick();
        chk("redir_valid", 32'(out_valid),   32'd1);
        chk("redir_pc",    32'(out_pc),      32'h40);
        chk("redir_next",  32'(out_next_pc), 32'h44);
        chk("redir_instr", out_instr,        32'h10);
        out_ready = 1'b1;
        tick();
        chk("redir_pc1", 32'(out_pc), 32'h44);
        tick();
        chk("redir_pc2", 32'(out_pc), 32'h48);
        chk("redir_err", 32'(error),  32'd0);

        // ---- misaligned redirect: sticky error, aligned fetch ----
        redirect    = 1'b1;
        redirect_pc = 16'h0042;
        tick();
        redirect = 1'b0;
        #1;
        chk("mis_error", 32'(error),       32'd1);
        chk("mis_addr",  32'(rom_address), 32'h40);
        tick();
        tick();
        chk("mis_valid", 32'(out_valid), 32'd1);
        chk("mis_pc",    32'(out_pc),    32'h40);
        tick();
        chk("mis_sticky", 32'(error), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mis_reset_clears", 32'(error), 32'd0);
        tick();
        reset = 1'b0;

        // ---- randomized traffic against a stream model ----
        exp_pc  = 16'h0000;
        exp_err = 1'b0;
        pops    = 0;
        for (int n = 0; n < 600; n++) begin
            rdy    = ($urandom_range(0, 3) != 0);
            redir  = ($urandom_range(0, 15) == 0);
            target = 16'($urandom);
            if ($urandom_range(0, 3) != 0) target[1:0] = 2'b00;
            out_ready   = rdy;
            redirect    = redir;
            redirect_pc = target;
            #1;
            chk("rnd_error",   32'(error),                32'(exp_err));
            chk("rnd_cnt_max", 32'(count <= 3'd4),        32'd1);
            chk("rnd_valid",   32'(out_valid),            32'(count != 3'd0));
            chk("rnd_align",   32'(rom_address[1:0]),     32'd0);
            if (redir) chk("rnd_redir_read", 32'(rom_read), 32'd0);
            if (out_valid && rdy) begin
                chk("rnd_pc",    32'(out_pc),      32'(exp_pc));
                chk("rnd_instr", out_instr,        rom_word(exp_pc));
                chk("rnd_next",  32'(out_next_pc), 32'(exp_pc + 16'd4));
                exp_pc = exp_pc + 16'd4;
                pops++;
            end
            if (redir) begin
                exp_pc = {target[15:2], 2'b00};
                if (target[1:0] != 2'b00) exp_err = 1'b1;
            end
            tick();
        end
        chk("rnd_progress", 32'(pops > 50), 32'd1);

        // ---- sustained throughput after random traffic ----
        out_ready = 1'b1;
        redirect  = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (out_valid) exp_pc = exp_pc + 16'd4;
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            chk("tput_valid", 32'(out_valid), 32'd1);
            chk("tput_pc",    32'(out_pc),    32'(exp_pc));
            exp_pc = exp_pc + 16'd4;
            tick();
        end
        chk("final_error", 32'(error), 32'(exp_err));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction decoder in the pipelined CPU.
- Owns the program counter and issues word reads to instruction ROM, which has one cycle of read latency.
- Buffers returned instructions, tagged with their PC, in a small prefetch FIFO and presents them to decode through a valid/ready handshake.
- Accepts a redirect (taken branch or jump) from execute; a redirect flushes the FIFO and discards any stale ROM response.

Parameters:
- ADDR_WIDTH, 16, width of a ROM byte address; PC arithmetic is modulo 2^ADDR_WIDTH.
- DEPTH, 4, prefetch FIFO entries; must be a power of two and at least 2.
- RESET_PC, 0, first fetch address after reset; must be word-aligned.

Ports:
- clk  in  1  the single clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- rom_read  out  1  fetch request issued this cycle.
- rom_address  out  ADDR_WIDTH  byte address of the request; bits [1:0] are always 0.
- rom_data  in  32  instruction word; valid the cycle after the request.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_WIDTH  new fetch address.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  instruction at the head.
- out_pc  out  ADDR_WIDTH  PC of the head instruction.
- out_next_pc  out  ADDR_WIDTH  out_pc + 4, wrapped.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- error  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - fetch_pc = RESET_PC; FIFO empty; inflight = 0; count = 0; error = 0.
  - out_valid = 0 and rom_read = 0 while reset is high.
- Outputs:
  - rom_address = fetch_pc at all times.
  - out_* come from the registered FIFO head; no combinational path from rom_data to out_*.
- pop: out_valid & out_ready. A transfer still counts in a redirect cycle.
- rom_read (issue) condition: !reset & !redirect & (count + inflight - pop < DEPTH).
  - This is combinational on out_ready; that path is accepted.
  - On issue, fetch_pc += 4 (wrapped), and inflight is set for the next cycle.
- Response: when inflight = 1 and redirect = 0, push {rom_data, request pc} at the clock edge. The entry is visible at the head the following cycle.
- Latency:
  - Request in cycle N, response data in N+1, out_valid in N+2.
  - First out_valid occurs 2 cycles after the first post-reset edge.
- Throughput: sustains 1 instruction per cycle when out_ready is held high.
- Simultaneous push and pop: count unchanged; FIFO order preserved.
- Full FIFO: the credit rule guarantees no push when full. A push into a full FIFO sets error, and the data is dropped.
- Empty FIFO: out_valid = 0; out_instr/out_pc hold their last values (don't care).
- Redirect (priority over push and issue):
  - Next cycle: FIFO empty, count = 0, inflight = 0, fetch_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle.
  - The first request to the new PC goes out the next cycle; its out_valid arrives 3 cycles after the redirect cycle.
- Back-to-back redirects: the last one wins; each redirect flushes again.
- Misaligned redirect_pc (bits [1:0] != 0): error is set and sticky until reset; fetch continues from the aligned address.
- Wrap: PC 2^ADDR_WIDTH - 4 is followed by 0 with no error.

Test Plan:
- Reset release, ROM returns word = address>>2, out_ready = 1: out_valid rises 2 cycles after release; out_pc = 0, 4, 8, 12… with out_instr = 0, 1, 2, 3…, one per cycle and no bubbles.
- DEPTH = 4, out_ready = 0 for 10 cycles: count saturates at 4 and rom_read goes low. Then out_ready = 1: out_pc = 0, 4, 8, 12, 16 consecutively with no gaps, no loss or duplication, and error = 0.
- Redirect to 0x40 with 3 entries buffered and one request inflight: next cycle count = 0 and out_valid = 0. Next output has out_pc = 0x40, out_next_pc = 0x44; no stale PCs appear afterwards.
- Redirect 0x42: error = 1 and stays set; fetch resumes at 0x40. Asserting reset clears error.
- RESET_PC = 0xFFF8, ADDR_WIDTH = 16: out_pc sequence is 0xFFF8, 0xFFFC, 0x0000; out_next_pc for 0xFFFC is 0x0000.
- Asynchronous reset asserted mid-stream (between clock edges, FIFO full): out_valid, rom_read and count drop immediately. After release, fetch restarts at RESET_PC.
